// File: rtl/uart_pkg.sv
// Shared definitions for the ASCII UART transmit path.
//   tx_state_t           : transmitter FSM states
//   DEFAULT_CLKS_PER_BIT : 50 MHz system clock / 115200 baud
//   ASCII_W              : character width
package uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam int unsigned ASCII_W              = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/char_fifo.sv
// Synchronous first-word-fall-through FIFO for buffered characters.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push, din  : write request and data; ignored while full, even when a pop
//                happens in the same cycle
//   pop        : read request; ignored while empty
//   dout       : head entry, valid while !empty
//   full/empty : derived from registered pointers
module char_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full (MSBs differ) from empty (equal).
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ascii_uart_tx.sv
// Buffered UART transmitter for decoded ASCII characters.
// Frames: 1 start bit (0), 8 data bits LSB first, STOP_BITS stop bits (1).
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-high reset
//   char_in    : character to send, sampled on a valid & ready edge
//   char_valid : char_in holds a character
//   char_ready : buffer can accept (not full)
//   tx         : registered serial line, idles high
//   busy       : frame in flight or characters buffered
module ascii_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ASCII_W-1:0] char_in,
  input  logic               char_valid,
  output logic               char_ready,
  output logic               tx,
  output logic               busy
);

  localparam int unsigned           BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0]     BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic                  STOP_LAST = 1'(STOP_BITS - 1);

  tx_state_t          state_q;
  logic [BAUD_W-1:0]  baud_q;
  logic [2:0]         bit_idx_q;
  logic               stop_idx_q;
  logic [ASCII_W-1:0] shift_q;
  logic               tx_q;

  logic [ASCII_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               baud_done;

  char_fifo #(
    .WIDTH (ASCII_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (char_valid),
    .pop   (fifo_pop),
    .din   (char_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_done  = (baud_q == BAUD_LAST);
  // Pop from IDLE, or at the very end of the last stop bit so the next start
  // bit follows without an idle gap.
  assign fifo_pop   = !fifo_empty &&
                      ((state_q == IDLE) ||
                       ((state_q == STOP) && baud_done && (stop_idx_q == STOP_LAST)));
  assign char_ready = !fifo_full;
  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign tx         = tx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          if (fifo_pop) begin
            shift_q <= fifo_dout;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              stop_idx_q <= 1'b0;
              tx_q       <= 1'b1;
              state_q    <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              // Next bit is taken pre-shift so tx lands on the boundary.
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (stop_idx_q == STOP_LAST) begin
              if (fifo_pop) begin
                shift_q <= fifo_dout;
                tx_q    <= 1'b0;
                state_q <= START;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule
